truth_table_sequencer: RTL and testbench
========================================

TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter HOLD, default 3, clock cycles each input vector is held; legal range 1..15.
REQ-002 Parameter EXPECT, default 8'h0C, expected DUT output per vector, bit index = {x,y,z}.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  synchronous run cancel; sampled only in APPLY.
REQ-007 x, y, z  output  1 each  stimulus driven to the combinational 3-input DUT.
REQ-008 f  input  1  DUT output, sampled by this block.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse at run completion.
REQ-011 pass  output  1  high when the last completed run had zero mismatches.
REQ-012 result  output  8  captured f per vector, bit index = {x,y,z}.
REQ-013 err_count  output  4  mismatches between result and EXPECT in the current or last run, 0..8.

Function
REQ-014 The block SHALL implement the states IDLE, APPLY and DONE, with an internal 3-bit vector index idx and a 4-bit hold counter cnt.
REQ-015 IDLE: on a clock edge with start=1, the block SHALL set idx=0, cnt=0, result=0, err_count=0, pass=0 and go to APPLY; with start=0 it SHALL remain in IDLE.
REQ-016 APPLY: {x,y,z} SHALL equal idx; in IDLE and DONE, {x,y,z} SHALL be 3'b000.
REQ-017 APPLY, cnt<HOLD-1: cnt SHALL increment, with no sampling.
REQ-018 APPLY, cnt==HOLD-1: result[idx] SHALL take f; err_count SHALL increment when f!=EXPECT[idx]; cnt SHALL return to 0.
REQ-019 On that same sampling edge, idx<7 SHALL cause idx to increment; idx==7 SHALL cause a transition to DONE.
REQ-020 Timing: the vector for idx n SHALL be driven from edge n*HOLD to edge (n+1)*HOLD, counted from the start-sampling edge (edge 0).
REQ-021 Timing: f SHALL be sampled on the last hold cycle; done SHALL be high for exactly the cycle following edge 8*HOLD.
REQ-022 DONE: done=1 for one cycle, then an unconditional return to IDLE.
REQ-023 On DONE entry, pass SHALL be set to 1 if the final err_count is 0, else 0.
REQ-024 busy SHALL be 1 exactly while in APPLY.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 start held high continuously SHALL launch a new run on the IDLE cycle following DONE.
REQ-027 abort=1 in APPLY SHALL take priority over sampling: the block goes to IDLE on that edge, with no sample on that edge and no done pulse.
REQ-028 After an abort, pass SHALL be 0, while result and err_count keep their partial values.
REQ-029 result, err_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-030 With HOLD=1, every APPLY cycle SHALL be a sampling cycle.
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from f to any output.

Reset
REQ-032 rst=1 SHALL immediately, without a clock edge, force state=IDLE, idx=0, cnt=0, and x=y=z=busy=done=pass=0, result=0, err_count=0.
REQ-033 Reset asserted mid-run SHALL discard the run; no done pulse SHALL follow deassertion.
REQ-034 After rst deasserts, the first start SHALL be honored on the next rising edge.

Verification
REQ-035 Correct DUT (f = ~x & y), HOLD=3, one-cycle start pulse -> xyz steps 000..111, 3 cycles each; done pulses after edge 24; result=8'h0C, err_count=0, pass=1.
REQ-036 f tied to 0 -> result=8'h00, err_count=2, pass=0; f = x & y (wrong DUT) -> result=8'hC0, err_count=4, pass=0.
REQ-037 f inverted from the correct DUT -> result=8'hF3, err_count=8, pass=0.
REQ-038 start pulsed during APPLY -> ignored; start held high -> back-to-back runs, with each done separated by one IDLE cycle.
REQ-039 abort asserted while idx=4 -> next cycle xyz=000, busy=0, no done, pass=0, result[3:0] populated, result[7:4]=0.
REQ-040 Asynchronous rst mid-run -> all outputs 0 before the next edge; then with HOLD=1, start -> done after edge 8 and result matches the DUT.

Source files
------------

// File: rtl/truth_table_sequencer_if.sv
// Stimulus/response bundle between the truth-table sequencer and its surroundings.
interface truth_table_sequencer_if;
    logic       start;
    logic       abort;
    logic       x;
    logic       y;
    logic       z;
    logic       f;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] result;
    logic [3:0] err_count;

    modport master (
        output start, abort, f,
        input  x, y, z, busy, done, pass, result, err_count
    );

    modport slave (
        input  start, abort, f,
        output x, y, z, busy, done, pass, result, err_count
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks {x,y,z} through 000..111 and holds each vector HOLD cycles; f is captured on the last hold cycle.
// Run latency is 8*HOLD cycles to done. There is no backpressure: start is only heard in IDLE, and abort only in APPLY.
module truth_table_sequencer #(
    parameter int unsigned HOLD   = 3,
    parameter logic [7:0]  EXPECT = 8'h0C
) (
    input  logic                    clk,
    input  logic                    rst,
    truth_table_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(HOLD - 1);

    state_t     state;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [2:0] xyz_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] result_q;
    logic [3:0] err_q;

    logic       mismatch;
    logic [3:0] err_next;

    assign mismatch = (bus.f != EXPECT[idx]);
    assign err_next = err_q + {3'b000, mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= 3'd0;
            cnt      <= 4'd0;
            xyz_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            result_q <= 8'h00;
            err_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= APPLY;
                        idx      <= 3'd0;
                        cnt      <= 4'd0;
                        xyz_q    <= 3'd0;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        result_q <= 8'h00;
                        err_q    <= 4'd0;
                    end
                end
                APPLY: begin
                    // abort wins over a sample landing on the same edge
                    if (bus.abort) begin
                        state  <= IDLE;
                        xyz_q  <= 3'd0;
                        busy_q <= 1'b0;
                        pass_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        result_q[idx] <= bus.f;
                        err_q         <= err_next;
                        cnt           <= 4'd0;
                        if (idx == 3'd7) begin
                            state  <= DONE;
                            xyz_q  <= 3'd0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_next == 4'd0);
                        end else begin
                            idx   <= idx + 3'd1;
                            xyz_q <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign {bus.x, bus.y, bus.z} = xyz_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.result    = result_q;
    assign bus.err_count = err_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: HOLD=3 and HOLD=1 sequencers driven against a switchable 3-input function model.
module tb_truth_table_sequencer;
    logic clk;
    logic rst;
    int   mode;
    int   n_pass;
    int   n_total;

    truth_table_sequencer_if bus3();
    truth_table_sequencer_if bus1();

    truth_table_sequencer #(.HOLD(3), .EXPECT(8'h0C)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));
    truth_table_sequencer #(.HOLD(1), .EXPECT(8'h0C)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    // mode 0: ~x&y, 1: stuck 0, 2: x&y, 3: ~(~x&y)
    always_comb begin
        case (mode)
            0:       bus3.f = ~bus3.x & bus3.y;
            1:       bus3.f = 1'b0;
            2:       bus3.f = bus3.x & bus3.y;
            default: bus3.f = ~(~bus3.x & bus3.y);
        endcase
    end

    always_comb begin
        case (mode)
            0:       bus1.f = ~bus1.x & bus1.y;
            1:       bus1.f = 1'b0;
            2:       bus1.f = bus1.x & bus1.y;
            default: bus1.f = ~(~bus1.x & bus1.y);
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulses start on the HOLD=3 unit and waits for done; returns the edge count and leaves the unit in IDLE.
    task automatic run3(output int e_done);
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        e_done = 0;
        while (bus3.done !== 1'b1 && e_done < 300) begin
            @(posedge clk);
            e_done++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic run1(output int e_done);
        bus1.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.start = 1'b0;
        e_done = 0;
        while (bus1.done !== 1'b1 && e_done < 300) begin
            @(posedge clk);
            e_done++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus3.busy, bus3.done, bus3.pass, bus3.x, bus3.y, bus3.z} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {bus3.busy, bus3.done, bus3.pass, bus3.x, bus3.y, bus3.z});
        else n_pass++;
        n_total++;
        if (bus3.result !== 8'h00 || bus3.err_count !== 4'd0)
            $display("FAIL reset_data: got result=%h err=%0d want 00/0", bus3.result, bus3.err_count);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_correct();
        int e;
        bit bad;
        mode = 0;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        n_total++;
        if (bus3.busy !== 1'b1) $display("FAIL first_start: busy got %b want 1", bus3.busy);
        else n_pass++;
        e = 0;
        bad = 1'b0;
        while (bus3.done !== 1'b1 && e < 300) begin
            if (e < 24 && ({bus3.x, bus3.y, bus3.z} !== 3'(e / 3) || bus3.busy !== 1'b1)) bad = 1'b1;
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        n_total++;
        if (e !== 24) $display("FAIL correct_done_edge: got %0d want 24", e);
        else n_pass++;
        n_total++;
        if (bad) $display("FAIL correct_vector_walk: got off-schedule xyz/busy want xyz=edge/3 busy=1");
        else n_pass++;
        n_total++;
        if (bus3.result !== 8'h0C || bus3.err_count !== 4'd0 || bus3.pass !== 1'b1)
            $display("FAIL correct_result: got %h/%0d/%b want 0c/0/1", bus3.result, bus3.err_count, bus3.pass);
        else n_pass++;
        n_total++;
        if ({bus3.busy, bus3.x, bus3.y, bus3.z} !== 4'b0)
            $display("FAIL correct_done_idle_outs: got %b want 0000", {bus3.busy, bus3.x, bus3.y, bus3.z});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus3.done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", bus3.done);
        else n_pass++;
    endtask

    task automatic test_wrong_dut();
        int          modes [3] = '{1, 2, 3};
        logic [7:0]  res   [3] = '{8'h00, 8'hC0, 8'hF3};
        logic [3:0]  errs  [3] = '{4'd2, 4'd4, 4'd8};
        int e;
        repeat (3) @(negedge clk);
        n_total++;
        if (bus3.pass !== 1'b1 || bus3.result !== 8'h0C)
            $display("FAIL idle_hold: got %b/%h want 1/0c", bus3.pass, bus3.result);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            mode = modes[i];
            run3(e);
            n_total++;
            if (e !== 24 || bus3.result !== res[i] || bus3.err_count !== errs[i] || bus3.pass !== 1'b0)
                $display("FAIL wrong_dut_%0d: got edge=%0d %h/%0d/%b want 24 %h/%0d/0",
                         modes[i], e, bus3.result, bus3.err_count, bus3.pass, res[i], errs[i]);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        int e;
        mode = 0;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        e = 0;
        while (bus3.done !== 1'b1 && e < 300) begin
            bus3.start = (e == 5);
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        bus3.start = 1'b0;
        n_total++;
        if (e !== 24 || bus3.result !== 8'h0C)
            $display("FAIL start_in_apply: got edge=%0d result=%h want 24/0c", e, bus3.result);
        else n_pass++;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus3.busy !== 1'b0) $display("FAIL start_in_done: busy got %b want 0", bus3.busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int e;
        int g;
        bit gap_bad;
        mode = 0;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        e = 0;
        while (bus3.done !== 1'b1 && e < 300) begin
            @(posedge clk);
            e++;
            @(negedge clk);
        end
        n_total++;
        if (e !== 24 || bus3.result !== 8'h0C)
            $display("FAIL b2b_first: got edge=%0d result=%h want 24/0c", e, bus3.result);
        else n_pass++;
        gap_bad = 1'b0;
        g = 0;
        do begin
            @(posedge clk);
            g++;
            @(negedge clk);
            if (g == 1 && (bus3.busy !== 1'b0 || bus3.done !== 1'b0)) gap_bad = 1'b1;
            if (g == 2 && bus3.busy !== 1'b1) gap_bad = 1'b1;
            if (g == 2) bus3.start = 1'b0;
        end while (bus3.done !== 1'b1 && g < 300);
        n_total++;
        if (gap_bad) $display("FAIL b2b_idle_gap: got wrong busy/done around restart want 0/0 then busy=1");
        else n_pass++;
        n_total++;
        if (g !== 26 || bus3.result !== 8'h0C)
            $display("FAIL b2b_second: got spacing=%0d result=%h want 26/0c", g, bus3.result);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (bus3.busy !== 1'b0) $display("FAIL b2b_stop: busy got %b want 0", bus3.busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit saw_done;
        mode = 3;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_total++;
        if ({bus3.x, bus3.y, bus3.z} !== 3'b100) $display("FAIL abort_pre_xyz: got %b want 100", {bus3.x, bus3.y, bus3.z});
        else n_pass++;
        bus3.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.abort = 1'b0;
        n_total++;
        if ({bus3.x, bus3.y, bus3.z, bus3.busy, bus3.done, bus3.pass} !== 6'b0)
            $display("FAIL abort_ctrl: got %b want 000000",
                     {bus3.x, bus3.y, bus3.z, bus3.busy, bus3.done, bus3.pass});
        else n_pass++;
        n_total++;
        if (bus3.result !== 8'h03 || bus3.err_count !== 4'd4)
            $display("FAIL abort_partial: got %h/%0d want 03/4", bus3.result, bus3.err_count);
        else n_pass++;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus3.done === 1'b1) saw_done = 1'b1;
        end
        n_total++;
        if (saw_done || bus3.result !== 8'h03) $display("FAIL abort_quiet: got done=%b result=%h want 0/03", saw_done, bus3.result);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit saw_done;
        mode = 0;
        bus3.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus3.start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_total++;
        if (bus3.busy !== 1'b1 || bus3.result !== 8'h04)
            $display("FAIL midrun_state: got busy=%b result=%h want 1/04", bus3.busy, bus3.result);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({bus3.x, bus3.y, bus3.z, bus3.busy, bus3.done, bus3.pass} !== 6'b0 ||
            bus3.result !== 8'h00 || bus3.err_count !== 4'd0)
            $display("FAIL async_reset: got ctrl=%b result=%h err=%0d want 000000/00/0",
                     {bus3.x, bus3.y, bus3.z, bus3.busy, bus3.done, bus3.pass}, bus3.result, bus3.err_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus3.done === 1'b1 || bus3.busy === 1'b1) saw_done = 1'b1;
        end
        n_total++;
        if (saw_done) $display("FAIL reset_discard: got done/busy activity want none");
        else n_pass++;
    endtask

    task automatic test_hold1();
        int e;
        mode = 0;
        run1(e);
        n_total++;
        if (e !== 8 || bus1.result !== 8'h0C || bus1.err_count !== 4'd0 || bus1.pass !== 1'b1)
            $display("FAIL hold1_correct: got edge=%0d %h/%0d/%b want 8 0c/0/1", e, bus1.result, bus1.err_count, bus1.pass);
        else n_pass++;
        mode = 2;
        run1(e);
        n_total++;
        if (e !== 8 || bus1.result !== 8'hC0 || bus1.err_count !== 4'd4 || bus1.pass !== 1'b0)
            $display("FAIL hold1_wrong: got edge=%0d %h/%0d/%b want 8 c0/4/0", e, bus1.result, bus1.err_count, bus1.pass);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        mode = 0;
        rst = 1'b1;
        bus3.start = 1'b0;
        bus3.abort = 1'b0;
        bus1.start = 1'b0;
        bus1.abort = 1'b0;
        @(negedge clk);
        test_reset();
        test_correct();
        test_wrong_dut();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_hold1();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
